// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder
package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [31:0] LED_ADDR_DEF = 32'hFFFF_FFF0;
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: byte-lane steering, load extension and access legality
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wrep,
    output logic [31:0] ldata,
    output logic        misalign,
    output logic        illegal
);
    logic [31:0] sh;
    // size from funct3[1:0], signedness from funct3[2]; stores only allow B/H/W
    always_comb begin
        sh       = rword >> {off, 3'b000};
        illegal  = we ? !(funct3 inside {F3_B, F3_H, F3_W})
                      : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misalign = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
        be       = (funct3[1:0] == 2'b00) ? 4'b0001 << off
                 : (funct3[1:0] == 2'b01) ? 4'b0011 << off : 4'b1111;
        wrep     = (funct3[1:0] == 2'b00) ? {4{wdata[7:0]}}
                 : (funct3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
        ldata    = (funct3[1:0] == 2'b00) ? {{24{sh[7] & !funct3[2]}}, sh[7:0]}
                 : (funct3[1:0] == 2'b01) ? {{16{sh[15] & !funct3[2]}}, sh[15:0]} : rword;
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding RAM/LED responder with configurable wait states
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] LED_ADDR    = LED_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        fault,
    output logic [7:0]  leds
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);

    mem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [7:0]  leds_q, leds_d;
    logic [31:0] rd_q;
    logic [31:0] mem [DEPTH];
    logic [3:0]  be;
    logic [31:0] wrep, ldata;
    logic        misalign, illegal, is_led, in_ram, bad, commit, capture;
    logic [IW-1:0] rd_idx;

    mem_lane_unit u_lane (
        .we(we_q), .funct3(f3_q), .off(addr_q[1:0]), .wdata(wdata_q), .rword(rd_q),
        .be(be), .wrep(wrep), .ldata(ldata), .misalign(misalign), .illegal(illegal)
    );

    // state and captured request; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            leds_q  <= leds_d;
        end
    end

    // next state: wait-state count only matters while in WAIT
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT:    if (cnt_q == LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // request capture, wait counter, legality and LED update
    always_comb begin
        capture = (state_q == IDLE) && req;
        cnt_d   = (state_q == WAIT && cnt_q != LAST) ? cnt_q + 4'd1 : 4'd0;
        we_d    = capture ? we : we_q;
        addr_d  = capture ? addr : addr_q;
        wdata_d = capture ? wdata : wdata_q;
        f3_d    = capture ? funct3 : f3_q;
        is_led  = addr_q == LED_ADDR;
        in_ram  = addr_q < 32'(4 * DEPTH);
        bad     = illegal || misalign || !(in_ram || (is_led && f3_q == F3_W));
        commit  = (state_q == RESP) && we_q && !bad;
        leds_d  = (commit && is_led) ? wdata_q[7:0] : leds_q;
        rd_idx  = (state_q == IDLE) ? addr[IW+1:2] : addr_q[IW+1:2];
    end

    // responses; rdata is forced to zero unless a good load completes
    always_comb begin
        ready = state_q == RESP;
        fault = ready && bad;
        rdata = (ready && !bad && !we_q) ? (is_led ? {24'b0, leds_q} : ldata) : 32'b0;
        leds  = leds_q;
    end

    // RAM: registered read every cycle, byte-masked write on the edge leaving RESP
    always_ff @(posedge clk) begin
        rd_q <= mem[rd_idx];
        if (commit && !is_led)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr_q[IW+1:2]][8*b +: 8] <= wrep[8*b +: 8];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus randomized checks against a byte-level memory model
module tb_mem_responder;
    localparam int DEPTH = 1024;
    localparam int WS = 1;
    localparam logic [31:0] LED = 32'hFFFF_FFF0;

    logic clk = 0, reset = 1, req = 0, we = 0;
    logic [31:0] addr = 0, wdata = 0, rdata;
    logic [2:0] funct3 = 0;
    logic ready, fault;
    logic [7:0] leds;
    int checks = 0, errors = 0;
    logic [7:0] mem_b [4*DEPTH];
    logic [7:0] ref_leds = 0;

    mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS), .LED_ADDR(LED)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .ready(ready), .fault(fault), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic logic ref_fault(input logic w, input logic [31:0] a, input logic [2:0] f);
        logic legal, aligned, in_range;
        legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        aligned = (a % size_of(f)) == 0;
        in_range = (a < 4 * DEPTH) || (a == LED && f == 3'd2);
        return !legal || !aligned || !in_range;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
        logic [31:0] v;
        if (a == LED) return {24'h0, ref_leds};
        v = 0;
        for (int i = 0; i < size_of(f); i++) v = v | (32'(mem_b[a + i]) << (8 * i));
        if (f == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, output logic [31:0] r, output logic fl);
        logic ef;
        logic [31:0] er;
        int k;
        ef = ref_fault(w, a, f);
        er = (ef || w) ? 32'h0 : ref_load(a, f);
        @(negedge clk);
        req = 1; we = w; addr = a; wdata = d; funct3 = f;
        @(posedge clk); #1;
        req = 0; we = 1'($urandom); addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        k = 0;
        while (ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency", k, WS);
        r = rdata;
        fl = fault;
        chk("fault", {31'b0, fault}, {31'b0, ef});
        if (ef || !w) chk("rdata", rdata, er);
        @(posedge clk); #1;
        if (!ef && w) begin
            if (a == LED) ref_leds = d[7:0];
            else for (int i = 0; i < size_of(f); i++) mem_b[a + i] = d[8*i +: 8];
        end
        chk("ready_pulse", {31'b0, ready}, 32'h0);
        chk("fault_idle", {31'b0, fault}, 32'h0);
        chk("leds", {24'b0, leds}, {24'b0, ref_leds});
    endtask

    initial begin
        logic [31:0] r, prev;
        logic fl;
        int seen;
        for (int i = 0; i < 4 * DEPTH; i++) mem_b[i] = 8'h00;
        #2;
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_leds", {24'b0, leds}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 0;

        for (int i = 0; i < 16; i++) txn(1'b1, 32'(4 * i), $urandom, 3'd2, r, fl);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, r, fl);
        txn(1'b0, 32'h10, 32'h0, 3'd2, r, fl);
        chk("lw10", r, 32'hDEADBEEF);
        txn(1'b1, 32'h11, 32'h80, 3'd0, r, fl);
        txn(1'b0, 32'h11, 32'h0, 3'd0, r, fl);
        chk("lb11", r, 32'hFFFFFF80);
        txn(1'b0, 32'h11, 32'h0, 3'd4, r, fl);
        chk("lbu11", r, 32'h00000080);
        txn(1'b0, 32'h10, 32'h0, 3'd2, r, fl);
        chk("lw10_b", r, 32'hDEAD80EF);

        txn(1'b1, 32'h20, 32'h0, 3'd2, r, fl);
        txn(1'b1, 32'h22, 32'h1234, 3'd1, r, fl);
        txn(1'b0, 32'h22, 32'h0, 3'd1, r, fl);
        chk("lh22", r, 32'h00001234);
        txn(1'b0, 32'h20, 32'h0, 3'd2, r, fl);
        chk("lw20", r, 32'h12340000);

        txn(1'b0, 32'h13, 32'h0, 3'd2, r, fl);
        chk("lw13_fault", {31'b0, fl}, 32'h1);
        txn(1'b1, 32'h15, 32'hFFFF, 3'd1, r, fl);
        chk("sh15_fault", {31'b0, fl}, 32'h1);
        txn(1'b0, 32'(4 * DEPTH), 32'h0, 3'd2, r, fl);
        chk("oor_fault", {31'b0, fl}, 32'h1);
        txn(1'b0, 32'h10, 32'h0, 3'd3, r, fl);
        chk("f3_fault", {31'b0, fl}, 32'h1);
        txn(1'b0, 32'h14, 32'h0, 3'd2, r, fl);
        txn(1'b0, 32'h10, 32'h0, 3'd2, r, fl);
        chk("lw10_kept", r, 32'hDEAD80EF);

        txn(1'b1, LED, 32'h000000A5, 3'd2, r, fl);
        chk("led_set", {24'b0, leds}, 32'hA5);
        txn(1'b0, LED, 32'h0, 3'd2, r, fl);
        chk("led_read", r, 32'h000000A5);
        txn(1'b1, LED, 32'h5A, 3'd0, r, fl);
        chk("sb_led_fault", {31'b0, fl}, 32'h1);
        chk("led_kept", {24'b0, leds}, 32'hA5);

        prev = ref_load(32'h30, 3'd2);
        @(negedge clk);
        req = 1; we = 1; addr = 32'h30; wdata = 32'h55AA55AA; funct3 = 3'd2;
        @(posedge clk); #1;
        req = 0;
        reset = 1;
        #1;
        chk("rst_mid_ready", {31'b0, ready}, 32'h0);
        @(negedge clk);
        reset = 0;
        ref_leds = 0;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready === 1'b1) seen++;
        end
        chk("rst_no_pulse", seen, 0);
        chk("rst_leds0", {24'b0, leds}, 32'h0);
        txn(1'b0, 32'h30, 32'h0, 3'd2, r, fl);
        chk("lw30_prior", r, prev);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 9);
            a = (kind < 8) ? 32'($urandom_range(0, 63))
              : (kind == 8) ? LED : 32'(4 * DEPTH + $urandom_range(0, 7));
            txn(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)), r, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
